// File: rtl/i2c_burst_seq_pkg.sv
// Shared definitions for the I2C burst sequencer: FSM state encoding,
// error codes and the slave address width.
package i2c_pkg;

    localparam int ADDR_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PTR       = 3'd1,
        ST_RD        = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_WAIT_IDLE = 3'd4,
        ST_DONE      = 3'd5
    } seq_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/i2c_burst_seq_if.sv
// Command/status handshake between the burst sequencer and the i2c_master engine.
interface i2c_burst_seq_if;
    import i2c_pkg::*;

    logic              m_ena;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_data_wr;
    logic              m_busy;
    logic              m_ack_error;
    logic [7:0]        m_data_rd;

    modport master (
        output m_ena, m_rw, m_addr, m_data_wr,
        input  m_busy, m_ack_error, m_data_rd
    );

    modport slave (
        input  m_ena, m_rw, m_addr, m_data_wr,
        output m_busy, m_ack_error, m_data_rd
    );

endinterface

// File: rtl/i2c_burst_seq_buf.sv
// Capture buffer: MAX_BYTES x 8, one write port, registered read port that
// returns the old contents when read and write hit the same index.
module i2c_seq_buf
    import i2c_pkg::*;
#(
    parameter int MAX_BYTES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [$clog2(MAX_BYTES)-1:0] waddr,
    input  logic [7:0]                   wdata,
    input  logic [$clog2(MAX_BYTES)-1:0] raddr,
    output logic [7:0]                   rdata
);

    logic [7:0] mem_r [MAX_BYTES];
    logic [7:0] rdata_r;

    // storage write, contents deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= 8'h00;
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/i2c_burst_seq.sv
// Register-pointer write + repeated-start burst read sequencer for i2c_master.
// Optional watchdog abort is enabled by defining I2C_BURST_SEQ_TIMEOUT_EN.
module i2c_burst_seq
    import i2c_pkg::*;
#(
    parameter int MAX_BYTES      = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            dev_addr,
    input  logic [7:0]                   reg_ptr,
    input  logic [$clog2(MAX_BYTES):0]   rd_len,
    output logic                         seq_busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic [$clog2(MAX_BYTES):0]   rd_count,
    input  logic [$clog2(MAX_BYTES)-1:0] buf_idx,
    output logic [7:0]                   buf_data,
    i2c_burst_seq_if.master              eng
);

    localparam int             CW      = $clog2(MAX_BYTES) + 1;
    localparam int             IW      = $clog2(MAX_BYTES);
    localparam logic [CW-1:0]  LEN_MAX = CW'(MAX_BYTES);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    seq_state_t        state_r, state_n;
    logic              m_ena_r, m_ena_n, m_rw_r, m_rw_n;
    logic [ADDR_W-1:0] m_addr_r, m_addr_n;
    logic [7:0]        m_data_wr_r, m_data_wr_n;
    logic              seq_busy_r, seq_busy_n, done_r, done_n, err_r, err_n;
    logic [1:0]        err_code_r, err_code_n;
    logic [CW-1:0]     rd_count_r, rd_count_n, issued_r, issued_n, len_r, len_n;
    logic              ptr_seen_r, ptr_seen_n;
    logic              busy_q_r, b_rise_s, b_fall_s, buf_we_s, wd_expire_s;

    assign b_rise_s = eng.m_busy & ~busy_q_r;
    assign b_fall_s = ~eng.m_busy & busy_q_r;

`ifdef I2C_BURST_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_r;

    assign wd_expire_s = (state_r != ST_IDLE) && (state_r != ST_DONE) &&
                         (wd_r == WW'(TIMEOUT_CYCLES - 1));

    // watchdog: reloads on engine activity and on its own expiry
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_r <= {WW{1'b0}};
        end else if ((state_r == ST_IDLE) || b_rise_s || b_fall_s || wd_expire_s) begin
            wd_r <= {WW{1'b0}};
        end else begin
            wd_r <= wd_r + WW'(1);
        end
    end
`else
    assign wd_expire_s = 1'b0;
`endif

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            m_ena_r     <= 1'b0;
            m_rw_r      <= 1'b0;
            m_addr_r    <= {ADDR_W{1'b0}};
            m_data_wr_r <= 8'h00;
            seq_busy_r  <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= ERR_NONE;
            rd_count_r  <= {CW{1'b0}};
            issued_r    <= {CW{1'b0}};
            len_r       <= {CW{1'b0}};
            ptr_seen_r  <= 1'b0;
            busy_q_r    <= 1'b0;
        end else begin
            state_r     <= state_n;
            m_ena_r     <= m_ena_n;
            m_rw_r      <= m_rw_n;
            m_addr_r    <= m_addr_n;
            m_data_wr_r <= m_data_wr_n;
            seq_busy_r  <= seq_busy_n;
            done_r      <= done_n;
            err_r       <= err_n;
            err_code_r  <= err_code_n;
            rd_count_r  <= rd_count_n;
            issued_r    <= issued_n;
            len_r       <= len_n;
            ptr_seen_r  <= ptr_seen_n;
            busy_q_r    <= eng.m_busy;
        end
    end

    // next-state and output decode
    always_comb begin
        state_n     = state_r;
        m_ena_n     = m_ena_r;
        m_rw_n      = m_rw_r;
        m_addr_n    = m_addr_r;
        m_data_wr_n = m_data_wr_r;
        seq_busy_n  = seq_busy_r;
        done_n      = 1'b0;
        err_n       = err_r;
        err_code_n  = err_code_r;
        rd_count_n  = rd_count_r;
        issued_n    = issued_r;
        len_n       = len_r;
        ptr_seen_n  = ptr_seen_r;
        buf_we_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    len_n       = (rd_len > LEN_MAX) ? LEN_MAX : rd_len;
                    m_addr_n    = dev_addr;
                    m_data_wr_n = reg_ptr;
                    m_rw_n      = 1'b0;
                    m_ena_n     = 1'b1;
                    seq_busy_n  = 1'b1;
                    err_n       = 1'b0;
                    err_code_n  = ERR_NONE;
                    rd_count_n  = {CW{1'b0}};
                    issued_n    = {CW{1'b0}};
                    ptr_seen_n  = 1'b0;
                    state_n     = ST_PTR;
                end else begin
                    m_ena_n = 1'b0;
                end
            end
            ST_PTR: begin
                if (b_rise_s) begin
                    if (len_r == {CW{1'b0}}) begin
                        m_ena_n = 1'b0;
                        state_n = ST_DRAIN;
                    end else begin
                        // pointer byte latched; the first read is now committed
                        m_rw_n   = 1'b1;
                        issued_n = CNT_ONE;
                        state_n  = ST_RD;
                    end
                end else begin
                    state_n = ST_PTR;
                end
            end
            ST_RD: begin
                if (b_rise_s) begin
                    issued_n = issued_r + CNT_ONE;
                    m_ena_n  = (issued_r == len_r) ? 1'b0 : m_ena_r;
                end else if (b_fall_s) begin
                    if (eng.m_ack_error) begin
                        err_n      = 1'b1;
                        err_code_n = ERR_NACK;
                        m_ena_n    = 1'b0;
                        state_n    = ST_WAIT_IDLE;
                    end else if (!ptr_seen_r) begin
                        ptr_seen_n = 1'b1;
                    end else begin
                        buf_we_s   = 1'b1;
                        rd_count_n = rd_count_r + CNT_ONE;
                        state_n    = (rd_count_n == len_r) ? ST_DONE : ST_RD;
                    end
                end else begin
                    state_n = ST_RD;
                end
            end
            ST_DRAIN: begin
                if (b_fall_s) begin
                    if (eng.m_ack_error) begin
                        err_n      = 1'b1;
                        err_code_n = ERR_NACK;
                        state_n    = ST_WAIT_IDLE;
                    end else begin
                        state_n = ST_DONE;
                    end
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            ST_WAIT_IDLE: begin
                state_n = eng.m_busy ? ST_WAIT_IDLE : ST_DONE;
            end
            ST_DONE: begin
                done_n     = 1'b1;
                seq_busy_n = 1'b0;
                m_ena_n    = 1'b0;
                state_n    = ST_IDLE;
            end
            default: begin
                m_ena_n = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

        // watchdog expiry overrides normal progress; a second expiry frees WAIT_IDLE
        if (wd_expire_s) begin
            buf_we_s = 1'b0;
            if (state_r == ST_WAIT_IDLE) begin
                state_n = ST_DONE;
            end else begin
                err_n      = 1'b1;
                err_code_n = ERR_TIMEOUT;
                m_ena_n    = 1'b0;
                state_n    = ST_WAIT_IDLE;
            end
        end else begin
            err_code_n = err_code_n;
        end
    end

    i2c_seq_buf #(
        .MAX_BYTES (MAX_BYTES)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (buf_we_s),
        .waddr (rd_count_r[IW-1:0]),
        .wdata (eng.m_data_rd),
        .raddr (buf_idx),
        .rdata (buf_data)
    );

    assign eng.m_ena     = m_ena_r;
    assign eng.m_rw      = m_rw_r;
    assign eng.m_addr    = m_addr_r;
    assign eng.m_data_wr = m_data_wr_r;
    assign seq_busy      = seq_busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign err_code      = err_code_r;
    assign rd_count      = rd_count_r;

endmodule

// File: doc/i2c_burst_seq.md
Name: i2c_burst_seq

Overview:
- Autonomous I2C command sequencer that drives the `ena/addr/rw/data_wr/busy/data_rd/ack_error` handshake of the `i2c_master` engine.
- Performs one "register-pointer write, then repeated-start N-byte read" transaction per start pulse. This is the standard sensor/IMU register burst.
- Captured bytes go into a local buffer that the CPU or the flight-control datapath reads afterwards.
- Sits directly upstream of `i2c_master`, beside the CPU-driven Wishbone I2C port. A top-level mux selects which of the two drives the engine.

Parameters:
- `MAX_BYTES`, 16, buffer depth and maximum read burst length (2..256).
- `TIMEOUT_CYCLES`, 2000000, `clk` cycles without a `m_busy` edge before abort (used only with the optional feature).

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; launches a sequence when idle
- `dev_addr`  in  7  7-bit slave address; sampled at `start`
- `reg_ptr`  in  8  register pointer byte; sampled at `start`
- `rd_len`  in  $clog2(MAX_BYTES)+1  bytes to read; sampled at `start`
- `seq_busy`  out  1  high from accepted start until done/error
- `done`  out  1  one-cycle pulse at end of sequence (success or error)
- `err`  out  1  sticky error flag; cleared by the next accepted start
- `err_code`  out  2  00 none, 01 NACK, 10 timeout
- `rd_count`  out  $clog2(MAX_BYTES)+1  bytes captured so far
- `buf_idx`  in  $clog2(MAX_BYTES)  buffer read index
- `buf_data`  out  8  buffer byte at `buf_idx`; registered, 1-cycle latency
- `m_ena`, `m_rw`  out  1 each  to `i2c_master`
- `m_addr`  out  7  to `i2c_master`
- `m_data_wr`  out  8  to `i2c_master`
- `m_busy`, `m_ack_error`  in  1 each  from `i2c_master`
- `m_data_rd`  in  8  from `i2c_master`

Behaviour:
- Reset values:
  - all outputs 0; state IDLE.
  - buffer contents are not reset.
- Edge detection: `busy_q` is `m_busy` delayed by one cycle.
  - `b_rise = m_busy & ~busy_q`.
  - `b_fall = ~m_busy & busy_q`.
- Engine contract:
  - The command is latched at `b_rise`.
  - Inputs may change after `b_rise`.
  - Holding `m_ena` high chains the next byte. Changing `m_rw` while chaining causes a repeated start.
  - At `b_fall`, the byte is complete: `m_data_rd` and `m_ack_error` are valid.
- Start handling:
  - `start` while `seq_busy` is ignored.
  - `rd_len` > `MAX_BYTES` is clamped to `MAX_BYTES`.
- IDLE:
  - On `start`: latch the inputs, clear `err`, `err_code` and `rd_count`, set `seq_busy`.
  - Drive `m_addr=dev_addr`, `m_rw=0`, `m_data_wr=reg_ptr`, `m_ena=1`. Go to PTR.
- PTR:
  - Wait for `b_rise`.
  - If `rd_len==0`: drop `m_ena`, go to DRAIN.
  - Otherwise: set `m_rw=1`, set `issued=1`, go to RD.
- RD:
  - On each `b_rise`: `issued++`. When `issued` reaches `rd_len`, drop `m_ena` in that same cycle.
  - On each `b_fall`:
    - The first fall belongs to the pointer write; ignore its data.
    - Each later fall writes `m_data_rd` to `buffer[rd_count]` and increments `rd_count`.
  - When `rd_count` reaches `rd_len` (last capture), go to DONE.
- DRAIN (pointer-only): on `b_fall`, go to DONE.
- Error:
  - Any `b_fall` with `m_ack_error=1` → set `err=1`, `err_code=01`, drop `m_ena`, go to WAIT_IDLE.
  - The byte carrying the NACK is not stored.
- WAIT_IDLE: stay until `m_busy==0`, then go to DONE.
- DONE: pulse `done` for 1 cycle, clear `seq_busy`, go to IDLE.
- Latency: from `start` to `m_ena=1` is 1 cycle.
- Buffer read port:
  - Independent of the state machine; readable at any time.
  - A read and a write to the same index in the same cycle returns the old data.
- Simultaneous `b_rise` and `b_fall` cannot occur; no handling is required.
- Reset mid-sequence: returns to IDLE and drops `m_ena` at the next edge. `i2c_master` shares `reset`.

Optional Feature:
- Macro: `I2C_BURST_SEQ_TIMEOUT_EN`.
- With the macro:
  - A watchdog counter reloads on every accepted `start` and every `m_busy` edge, and runs in any state except IDLE.
  - On reaching `TIMEOUT_CYCLES-1`: `err=1`, `err_code=10`, `m_ena=0`, go to WAIT_IDLE.
  - WAIT_IDLE then exits unconditionally after a further `TIMEOUT_CYCLES`, so a stuck `m_busy` cannot hang the sequencer.
- Without the macro: no counter is built; `err_code=10` never occurs, and the sequencer waits indefinitely.

Decomposition:
- Shared package `i2c_pkg` holds:
  - state encoding (IDLE, PTR, RD, DRAIN, WAIT_IDLE, DONE);
  - `err_code` constants (`ERR_NONE`, `ERR_NACK`, `ERR_TIMEOUT`);
  - the 7-bit address width.
- One sub-module, `i2c_seq_buf`: a `MAX_BYTES` x 8 single-write, registered-read buffer.

Test Plan (bench uses a behavioural `i2c_master` model: `busy` high for 20 cycles per byte, 2 low cycles between chained bytes):
- `start`, `dev_addr=0x68`, `reg_ptr=0x3B`, `rd_len=6`; model returns 0x11..0x16 → `m_rw` 0 then 1 after first `b_rise`, 7 busy pulses, buffer[0..5]=0x11..0x16, `rd_count=6`, one `done` pulse, `err=0`.
- `rd_len=0`, `reg_ptr=0x6B` → exactly one busy pulse with `m_rw=0`, `m_data_wr=0x6B`, `done` pulse, `rd_count=0`.
- Model asserts `ack_error` on the address phase → `err=1`, `err_code=01`, `rd_count=0`, `m_ena` low within 1 cycle of `b_fall`, `done` once `m_busy` is low.
- `rd_len=20` with `MAX_BYTES=16` → exactly 16 reads, `rd_count=16`; a second `start` pulsed mid-sequence is ignored.
- `reset` asserted during the third read byte → all outputs 0 next cycle; a new `start` afterwards completes normally.
- Macro defined, `TIMEOUT_CYCLES=100`, model holds `busy` high forever → `err_code=10` at cycle 100, `done` pulse at cycle 200.
